// File: rtl/uart_loader_ctrl_if.sv
// Byte stream in from the UART receiver, instruction-memory write port and
// load status out. The loader core uses the slave view; the byte source uses master.
interface uart_loader_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_byte_i;
  logic              rx_valid_i;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              cpu_hold_o;
  logic              load_done_o;
  logic              load_err_o;
  logic [1:0]        err_code_o;
  logic [7:0]        word_count_o;

  modport master (
    output rx_byte_i, rx_valid_i,
    input  imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o,
    input  load_done_o, load_err_o, err_code_o, word_count_o
  );

  modport slave (
    input  rx_byte_i, rx_valid_i,
    output imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o,
    output load_done_o, load_err_o, err_code_o, word_count_o
  );
endinterface

// File: rtl/uart_loader_ctrl.sv
// Parses SYNC/LEN/data/CSUM/END frames from the UART byte stream, writes
// little-endian 32-bit words to instruction memory and stalls the CPU until a clean load.
module uart_loader_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hAB,
  parameter logic [7:0] END_BYTE    = 8'hCD,
  parameter int         ADDR_W      = 10,
  parameter int         BASE_ADDR   = 0,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  uart_loader_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_ENDB} state_t;

  localparam logic [1:0]  E_NONE    = 2'b00;
  localparam logic [1:0]  E_FRAME   = 2'b01;
  localparam logic [1:0]  E_CSUM    = 2'b10;
  localparam logic [1:0]  E_TIMEOUT = 2'b11;
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_len, w_len_nxt;
  logic [7:0]        r_csum, w_csum_nxt;
  logic [1:0]        r_bidx, w_bidx_nxt;
  logic [7:0]        r_widx, w_widx_nxt;
  logic [23:0]       r_shift, w_shift_nxt;
  logic [31:0]       r_timer, w_timer_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              r_hold, w_hold_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [1:0]        r_ecode, w_ecode_nxt;
  logic [7:0]        r_wcnt, w_wcnt_nxt;

  logic [7:0]        w_byte;
  logic [31:0]       w_timer_inc;
  logic              w_expire;

  assign w_byte      = bus.rx_byte_i;
  assign w_timer_inc = r_timer + 32'd1;
  // Expiry is flagged on the edge where the timer would reach TIMEOUT_CYC-1;
  // a byte arriving on that same edge takes priority.
  assign w_expire    = (r_state != S_IDLE) && !bus.rx_valid_i && (w_timer_inc >= TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_csum  <= '0;
      r_bidx  <= '0;
      r_widx  <= '0;
      r_shift <= '0;
      r_timer <= '0;
      r_we    <= 1'b0;
      r_addr  <= BASE;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ecode <= E_NONE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_csum  <= w_csum_nxt;
      r_bidx  <= w_bidx_nxt;
      r_widx  <= w_widx_nxt;
      r_shift <= w_shift_nxt;
      r_timer <= w_timer_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_hold  <= w_hold_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_ecode <= w_ecode_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_csum_nxt  = r_csum;
    w_bidx_nxt  = r_bidx;
    w_widx_nxt  = r_widx;
    w_shift_nxt = r_shift;
    w_timer_nxt = r_timer;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_hold_nxt  = r_hold;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_ecode_nxt = r_ecode;
    w_wcnt_nxt  = r_wcnt;

    if (bus.rx_valid_i) begin
      w_timer_nxt = '0;
    end else if (r_state != S_IDLE) begin
      w_timer_nxt = w_timer_inc;
    end

    if (w_expire) begin
      w_state_nxt = S_IDLE;
      w_err_nxt   = 1'b1;
      w_ecode_nxt = E_TIMEOUT;
      w_timer_nxt = '0;
    end else if (bus.rx_valid_i) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_byte == SYNC_BYTE) begin
            w_state_nxt = S_LEN;
            w_hold_nxt  = 1'b1;
            w_ecode_nxt = E_NONE;
            w_csum_nxt  = '0;
            w_widx_nxt  = '0;
            w_bidx_nxt  = '0;
          end
        end
        S_LEN: begin
          if (w_byte == 8'd0) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
            w_ecode_nxt = E_FRAME;
          end else begin
            w_len_nxt   = w_byte;
            w_csum_nxt  = r_csum ^ w_byte;
            w_bidx_nxt  = '0;
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          // Bytes shift in from the top so byte 0 ends up in bits [7:0].
          w_csum_nxt  = r_csum ^ w_byte;
          w_bidx_nxt  = r_bidx + 2'd1;
          w_shift_nxt = {w_byte, r_shift[23:8]};
          if (r_bidx == 2'd3) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = BASE + ADDR_W'(r_widx);
            w_wdata_nxt = {w_byte, r_shift};
            w_widx_nxt  = r_widx + 8'd1;
            if (r_widx == (r_len - 8'd1)) begin
              w_state_nxt = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (w_byte == r_csum) begin
            w_state_nxt = S_ENDB;
          end else begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
            w_ecode_nxt = E_CSUM;
          end
        end
        S_ENDB: begin
          w_state_nxt = S_IDLE;
          if (w_byte == END_BYTE) begin
            w_done_nxt = 1'b1;
            w_hold_nxt = 1'b0;
            w_wcnt_nxt = r_len;
          end else begin
            w_err_nxt   = 1'b1;
            w_ecode_nxt = E_FRAME;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.imem_we_o    = r_we;
  assign bus.imem_addr_o  = r_addr;
  assign bus.imem_wdata_o = r_wdata;
  assign bus.cpu_hold_o   = r_hold;
  assign bus.load_done_o  = r_done;
  assign bus.load_err_o   = r_err;
  assign bus.err_code_o   = r_ecode;
  assign bus.word_count_o = r_wcnt;

endmodule
